cnn_host_sequencer: RTL and testbench

CNN_HOST_SEQUENCER -- requirements
Module: cnn_host_sequencer

---
 rtl/cnn_host_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cnn_host_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_host_sequencer.sv
// Host-side sequencer for a CNN accelerator: loads image, weights and bias, starts a job, then streams the results out.
// Load writes pass straight through with no added latency; result beats hold under m_ready back-pressure.
module cnn_host_sequencer #(
    parameter int DATA_WIDTH          = 8,
    parameter int IMG_SIZE            = 64,
    parameter int KERNEL_AREA         = 9,
    parameter int POOL_OUT_AREA       = 9,
    parameter int IMG_ADDR_WIDTH      = 6,
    parameter int POOL_OUT_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_go,
    input  logic                           abort,
    output logic                           busy,
    output logic                           job_done,
    output logic                           err_timeout,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic                           m_valid,
    output logic                           m_last,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [IMG_ADDR_WIDTH-1:0]      acc_wr_addr,
    output logic [DATA_WIDTH-1:0]          acc_data_in,
    output logic                           acc_wr_en,
    output logic                           acc_mem_select,
    output logic                           acc_start,
    input  logic                           acc_done,
    output logic [POOL_OUT_ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [DATA_WIDTH-1:0]          acc_data_out
);

    // One counter serves as load address, watchdog and read address, so it must fit the widest use.
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_W0 = (TO_W > IMG_ADDR_WIDTH) ? TO_W : IMG_ADDR_WIDTH;
    localparam int CNT_W  = (CNT_W0 > POOL_OUT_ADDR_WIDTH) ? CNT_W0 : POOL_OUT_ADDR_WIDTH;

    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_SIZE - 1);
    localparam logic [CNT_W-1:0] BIAS_IDX = CNT_W'(KERNEL_AREA);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(POOL_OUT_AREA - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IMG,
        S_LOAD_KER,
        S_START,
        S_WAIT_DONE,
        S_READ
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_start_q, acc_start_d;
    logic             job_done_q, job_done_d;
    logic             err_timeout_q, err_timeout_d;

    logic loading;
    logic reading;
    logic s_fire;
    logic m_fire;

    assign loading = (state_q == S_LOAD_IMG) || (state_q == S_LOAD_KER);
    assign reading = (state_q == S_READ);
    assign s_fire  = loading && s_valid;
    assign m_fire  = reading && m_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_start_d   = acc_start_q;
        job_done_d    = 1'b0;
        err_timeout_d = err_timeout_q;

        if (abort) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            acc_start_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_go) begin
                        state_d       = S_LOAD_IMG;
                        cnt_d         = '0;
                        err_timeout_d = 1'b0;
                    end
                end
                S_LOAD_IMG: begin
                    if (s_fire) begin
                        if (cnt_q == IMG_LAST) begin
                            state_d = S_LOAD_KER;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_LOAD_KER: begin
                    // The beat after the last weight is the bias; taking it launches the job.
                    if (s_fire) begin
                        if (cnt_q == BIAS_IDX) begin
                            state_d     = S_START;
                            cnt_d       = '0;
                            acc_start_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_d     = S_WAIT_DONE;
                    cnt_d       = '0;
                    acc_start_d = 1'b1;
                end
                S_WAIT_DONE: begin
                    // acc_done wins over the watchdog if both land in the same cycle.
                    if (acc_done) begin
                        state_d     = S_READ;
                        cnt_d       = '0;
                        acc_start_d = 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d       = S_IDLE;
                        cnt_d         = '0;
                        acc_start_d   = 1'b0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (m_fire) begin
                        if (cnt_q == RES_LAST) begin
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                            job_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    acc_start_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_start_q   <= 1'b0;
            job_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_start_q   <= acc_start_d;
            job_done_q    <= job_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Data/address outputs are gated by state so they read as zero whenever the path is idle.
    assign busy           = (state_q != S_IDLE);
    assign job_done       = job_done_q;
    assign err_timeout    = err_timeout_q;
    assign acc_start      = acc_start_q;
    assign s_ready        = loading;
    assign acc_wr_en      = s_fire;
    assign acc_data_in    = loading ? s_data : '0;
    assign acc_wr_addr    = loading ? cnt_q[IMG_ADDR_WIDTH-1:0] : '0;
    assign acc_mem_select = (state_q == S_LOAD_KER);
    assign m_valid        = reading;
    assign m_last         = reading && (cnt_q == RES_LAST);
    assign m_data         = reading ? acc_data_out : '0;
    assign acc_rd_addr    = reading ? cnt_q[POOL_OUT_ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_cnn_host_sequencer.sv
// Directed bench: full jobs, stalls, watchdog, abort, reset and ignored commands.
module tb_cnn_host_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_go;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       acc_done;

    logic       busy, job_done, err_timeout, s_ready, m_valid, m_last;
    logic [7:0] m_data, acc_data_in, acc_data_out;
    logic [5:0] acc_wr_addr;
    logic       acc_wr_en, acc_mem_select, acc_start;
    logic [3:0] acc_rd_addr;

    logic       t_busy, t_job_done, t_err_timeout, t_s_ready, t_m_valid, t_m_last;
    logic [7:0] t_m_data, t_acc_data_in, t_acc_data_out;
    logic [5:0] t_acc_wr_addr;
    logic       t_acc_wr_en, t_acc_mem_select, t_acc_start;
    logic [3:0] t_acc_rd_addr;

    logic [34:0] main_outs;
    logic [34:0] t_outs;

    assign main_outs = {busy, job_done, err_timeout, s_ready, m_valid, m_last, acc_wr_en,
                        acc_mem_select, acc_start, acc_wr_addr, acc_data_in, acc_rd_addr, m_data};
    assign t_outs    = {t_busy, t_job_done, t_err_timeout, t_s_ready, t_m_valid, t_m_last, t_acc_wr_en,
                        t_acc_mem_select, t_acc_start, t_acc_wr_addr, t_acc_data_in, t_acc_rd_addr, t_m_data};

    // Result memory of the accelerator: word k reads as 0xA0 + k.
    assign acc_data_out   = 8'hA0 + {4'h0, acc_rd_addr};
    assign t_acc_data_out = 8'hA0 + {4'h0, t_acc_rd_addr};

    cnn_host_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go), .abort(abort),
        .busy(busy), .job_done(job_done), .err_timeout(err_timeout),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .m_data(m_data),
        .acc_wr_addr(acc_wr_addr), .acc_data_in(acc_data_in), .acc_wr_en(acc_wr_en),
        .acc_mem_select(acc_mem_select), .acc_start(acc_start), .acc_done(acc_done),
        .acc_rd_addr(acc_rd_addr), .acc_data_out(acc_data_out)
    );

    cnn_host_sequencer #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go), .abort(abort),
        .busy(t_busy), .job_done(t_job_done), .err_timeout(t_err_timeout),
        .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data),
        .m_valid(t_m_valid), .m_last(t_m_last), .m_ready(m_ready), .m_data(t_m_data),
        .acc_wr_addr(t_acc_wr_addr), .acc_data_in(t_acc_data_in), .acc_wr_en(t_acc_wr_en),
        .acc_mem_select(t_acc_mem_select), .acc_start(t_acc_start), .acc_done(acc_done),
        .acc_rd_addr(t_acc_rd_addr), .acc_data_out(t_acc_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          done_at = 201;
    bit          done_en = 1'b0;
    int          run      = 0;
    int          last_run = 0;
    logic [14:0] wr_log [0:1023];
    int          wr_n = 0;
    logic [8:0]  res_log [0:1023];
    int          res_n = 0;
    int          jd_n  = 0;
    int          mv_n  = 0;
    int          tmv_n = 0;

    // Monitors and accelerator model, sampled on the falling edge.
    always @(negedge clk) begin
        if (acc_wr_en && wr_n < 1024) begin
            wr_log[wr_n] = {acc_mem_select, acc_wr_addr, acc_data_in};
            wr_n++;
        end
        if (m_valid && m_ready && res_n < 1024) begin
            res_log[res_n] = {m_last, m_data};
            res_n++;
        end
        if (job_done)  jd_n++;
        if (m_valid)   mv_n++;
        if (t_m_valid) tmv_n++;
        if (acc_start) begin
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        acc_done = done_en && acc_start && (run == done_at);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        cmd_go = 1'b1;
        step();
        cmd_go = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                step();
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    task automatic load_all(input bit gaps);
        for (int i = 0; i < 64; i++) send_word(8'(i), gaps);
        for (int i = 0; i < 9; i++)  send_word(8'(i + 1), gaps);
        send_word(8'd5, gaps);
    endtask

    task automatic wait_mvalid();
        for (int i = 0; i < 1000 && m_valid !== 1'b1; i++) step();
        check("mvalid_arrives", m_valid, 1);
    endtask

    task automatic read_all(input int stall_beat);
        for (int b = 0; b < 9; b++) begin
            if (b == stall_beat) begin
                m_ready = 1'b0;
                repeat (5) begin
                    step();
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, 160 + b);
                end
                m_ready = 1'b1;
            end
            check("beat_data", m_data, 160 + b);
            check("beat_last", m_last, (b == 8) ? 1 : 0);
            step();
        end
    endtask

    task automatic check_writes(input int base);
        check("write_count", wr_n - base, 74);
        for (int i = 0; i < 64; i++)
            check("img_write", wr_log[base + i], i * 256 + i);
        for (int j = 0; j < 10; j++)
            check("ker_write", wr_log[base + 64 + j], 16384 + j * 256 + ((j < 9) ? j + 1 : 5));
    endtask

    task automatic check_results(input int base);
        check("result_count", res_n - base, 9);
        for (int i = 0; i < 9; i++)
            check("result_log", res_log[base + i], ((i == 8) ? 256 : 0) + 160 + i);
    endtask

    initial begin
        int wr_base, res_base, jd_base, mv_base, tmv_base;

        rst_n = 1'b0; cmd_go = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        #12;
        check("reset_outs", main_outs, 0);
        check("reset_outs_to", t_outs, 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_reset", busy, 0);

        // Full job, no gaps, accelerator finishes after 200 waiting cycles.
        done_en = 1'b1; done_at = 201;
        wr_base = wr_n; res_base = res_n; jd_base = jd_n;
        go();
        check("go_busy", busy, 1);
        check("go_s_ready", s_ready, 1);
        check("go_sel_img", acc_mem_select, 0);
        load_all(1'b0);
        check("start_acc_start", acc_start, 1);
        check("start_s_ready", s_ready, 0);
        wait_mvalid();
        read_all(-1);
        check("job_done_pulse", job_done, 1);
        check("idle_after_job", busy, 0);
        check("mvalid_after_job", m_valid, 0);
        step();
        check("job_done_drop", job_done, 0);
        check("acc_start_cycles", last_run, 201);
        check_writes(wr_base);
        check_results(res_base);
        check("job_done_count", jd_n - jd_base, 1);

        // Same job with input gaps and a 5-cycle stall on result beat 4.
        wr_base = wr_n; res_base = res_n; jd_base = jd_n;
        go();
        load_all(1'b1);
        wait_mvalid();
        read_all(3);
        check("job_done_pulse_stall", job_done, 1);
        step();
        check_writes(wr_base);
        check_results(res_base);
        check("job_done_count_stall", jd_n - jd_base, 1);

        // cmd_go during WAIT_DONE is ignored; then cmd_go with abort in IDLE is ignored.
        done_at = 20;
        res_base = res_n; jd_base = jd_n;
        go();
        load_all(1'b0);
        repeat (3) step();
        cmd_go = 1'b1;
        step();
        cmd_go = 1'b0;
        check("wait_go_busy", busy, 1);
        check("wait_go_acc_start", acc_start, 1);
        check("wait_go_s_ready", s_ready, 0);
        wait_mvalid();
        read_all(-1);
        check("wait_go_job_done", job_done, 1);
        step();
        check("wait_go_start_cycles", last_run, 20);
        check_results(res_base);
        cmd_go = 1'b1; abort = 1'b1;
        step();
        cmd_go = 1'b0; abort = 1'b0;
        check("go_abort_idle", busy, 0);
        check("go_abort_s_ready", s_ready, 0);
        step();
        check("go_abort_still_idle", busy, 0);
        check("go_abort_no_done", jd_n - jd_base, 1);

        // Abort during LOAD_KER at cnt=3, then a new job restarts at image address 0.
        jd_base = jd_n;
        go();
        for (int i = 0; i < 64; i++) send_word(8'(i), 1'b0);
        for (int i = 0; i < 3; i++)  send_word(8'(i + 1), 1'b0);
        s_valid = 1'b1; s_data = 8'd4; abort = 1'b1;
        #1;
        check("abort_ker_addr", acc_wr_addr, 3);
        check("abort_ker_sel", acc_mem_select, 1);
        step();
        abort = 1'b0; s_valid = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_s_ready", s_ready, 0);
        step();
        check("abort_no_done", jd_n - jd_base, 0);
        go();
        s_valid = 1'b1; s_data = 8'h77;
        #1;
        check("restart_addr", acc_wr_addr, 0);
        check("restart_sel", acc_mem_select, 0);
        check("restart_wr_en", acc_wr_en, 1);
        check("restart_data", acc_data_in, 8'h77);
        step();
        s_valid = 1'b0;
        check("restart_addr_next", acc_wr_addr, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("restart_abort_idle", busy, 0);

        // Watchdog on the TIMEOUT_CYCLES=16 instance: acc_done never arrives.
        done_en = 1'b0;
        tmv_base = tmv_n;
        go();
        load_all(1'b0);
        check("to_start", t_acc_start, 1);
        repeat (16) step();
        check("to_wait_busy", t_busy, 1);
        check("to_wait_no_err", t_err_timeout, 0);
        step();
        check("to_err", t_err_timeout, 1);
        check("to_acc_start", t_acc_start, 0);
        check("to_idle", t_busy, 0);
        step();
        check("to_err_sticky", t_err_timeout, 1);
        check("to_no_mvalid", tmv_n - tmv_base, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("to_abort_keeps_err", t_err_timeout, 1);
        check("to_main_idle", busy, 0);
        go();
        check("to_go_clears_err", t_err_timeout, 0);
        check("to_go_busy", t_busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        done_en = 1'b1;

        // Asynchronous reset during READ at cnt=4.
        done_at = 10;
        go();
        load_all(1'b0);
        wait_mvalid();
        repeat (4) step();
        check("rd4_addr", acc_rd_addr, 4);
        check("rd4_data", m_data, 8'hA4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", main_outs, 0);
        check("async_reset_outs_to", t_outs, 0);
        step();
        rst_n = 1'b1;
        mv_base = mv_n;
        repeat (20) step();
        check("post_reset_no_mvalid", mv_n - mv_base, 0);
        check("post_reset_idle", busy, 0);
        check("main_never_timeout", err_timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
